imem_prog_loader: RTL and testbench

//  Boot-time program loader upstream of the instruction memory (IM) and fetch stage.

---
 rtl/imem_prog_loader_pkg.sv | 22 ++
 rtl/imem_prog_loader_timeout.sv | 31 +++
 rtl/imem_prog_loader.sv | 141 ++++++++++++++
 tb/tb_imem_prog_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_prog_loader_pkg.sv
// Shared types for the boot-time instruction-memory loader.
// This package holds the frame state encoding and the byte and word widths.
package imem_prog_loader_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;

   // One state per frame field, plus two terminal states.
   typedef enum logic [2:0] {
      ST_RX_CNT  = 3'd0,
      ST_RX_HI   = 3'd1,
      ST_RX_LO   = 3'd2,
      ST_RX_CSUM = 3'd3,
      ST_DONE    = 3'd4,
      ST_ERR     = 3'd5
   } state_e;

   function automatic logic is_rx(input state_e s);
      return (s == ST_RX_CNT) || (s == ST_RX_HI) || (s == ST_RX_LO) || (s == ST_RX_CSUM);
   endfunction

endpackage

// File: rtl/imem_prog_loader_timeout.sv
// Idle counter for the middle of a frame.
// It flags expiry when TIMEOUT consecutive cycles pass without a byte.
module imem_prog_loader_timeout #(
   parameter int TIMEOUT = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_hs,
   output logic o_expire
);

   localparam int CTR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CTR_W-1:0] LIMIT = CTR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   logic [CTR_W-1:0] r_ctr;

   // Saturates at LIMIT so a disabled timeout (TIMEOUT=0) never wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ctr <= '0;
      end else if (!i_en || i_hs) begin
         r_ctr <= '0;
      end else if (r_ctr != LIMIT) begin
         r_ctr <= r_ctr + CTR_W'(1);
      end
   end

   assign o_expire = (TIMEOUT != 0) && i_en && !i_hs && (r_ctr == LIMIT);

endmodule

// File: rtl/imem_prog_loader.sv
// Loads a CNT/{HI,LO}xN/CSUM byte frame into instruction memory.
// The core stays in reset until the frame checksum has been verified.
module imem_prog_loader
   import imem_prog_loader_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              start,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [15:0]       im_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              err
);

   state_e              r_state;
   state_e              w_next;

   logic                r_in_ready;
   logic                r_im_we;
   logic [ADDR_W-1:0]   r_im_addr;
   logic [WORD_W-1:0]   r_im_wdata;
   logic                r_core_rst;
   logic                r_done;
   logic                r_err;

   logic [ADDR_W:0]     r_word_idx;
   logic [ADDR_W:0]     r_total;
   logic [BYTE_W-1:0]   r_csum;
   logic [BYTE_W-1:0]   r_hi;

   logic                w_hs;
   logic                w_timed;
   logic                w_timeout;
   logic                w_last;
   logic [ADDR_W:0]     w_idx_nxt;
   logic [ADDR_W:0]     w_cnt_words;

   assign w_hs        = in_valid & r_in_ready;
   assign w_timed     = (r_state == ST_RX_HI) || (r_state == ST_RX_LO) || (r_state == ST_RX_CSUM);
   assign w_idx_nxt   = r_word_idx + {{ADDR_W{1'b0}}, 1'b1};
   assign w_last      = (w_idx_nxt == r_total);
   // A CNT byte of zero means a full 2**ADDR_W-word image.
   assign w_cnt_words = (in_data == '0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W + 1)'(in_data);

   imem_prog_loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_timed),
      .i_hs     (w_hs),
      .o_expire (w_timeout)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_RX_CNT;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_RX_CNT:  if (w_hs) w_next = ST_RX_HI;
         ST_RX_HI:   if (w_hs) w_next = ST_RX_LO;
                     else if (w_timeout) w_next = ST_ERR;
         ST_RX_LO:   if (w_hs) w_next = w_last ? ST_RX_CSUM : ST_RX_HI;
                     else if (w_timeout) w_next = ST_ERR;
         ST_RX_CSUM: if (w_hs) w_next = (in_data == r_csum) ? ST_DONE : ST_ERR;
                     else if (w_timeout) w_next = ST_ERR;
         ST_DONE,
         ST_ERR:     if (start) w_next = ST_RX_CNT;
         default:    w_next = ST_RX_CNT;
      endcase
   end

   // Status outputs are registered from the next state so they align with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_in_ready <= 1'b1;
         r_im_we    <= 1'b0;
         r_im_addr  <= '0;
         r_im_wdata <= '0;
         r_core_rst <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_word_idx <= '0;
         r_total    <= '0;
         r_csum     <= '0;
         r_hi       <= '0;
      end else begin
         r_in_ready <= is_rx(w_next);
         r_core_rst <= (w_next != ST_DONE);
         r_done     <= (w_next == ST_DONE);
         r_err      <= (w_next == ST_ERR);
         r_im_we    <= 1'b0;
         case (r_state)
            ST_RX_CNT: if (w_hs) begin
               r_total <= w_cnt_words;
               r_csum  <= in_data;
            end
            ST_RX_HI: if (w_hs) begin
               r_hi   <= in_data;
               r_csum <= r_csum ^ in_data;
            end
            ST_RX_LO: if (w_hs) begin
               r_csum     <= r_csum ^ in_data;
               r_im_we    <= 1'b1;
               r_im_addr  <= r_word_idx[ADDR_W-1:0];
               r_im_wdata <= {r_hi, in_data};
               r_word_idx <= w_idx_nxt;
            end
            ST_DONE,
            ST_ERR: if (start) begin
               r_word_idx <= '0;
               r_csum     <= '0;
            end
            default: ;
         endcase
      end
   end

   assign in_ready = r_in_ready;
   assign im_we    = r_im_we;
   assign im_addr  = r_im_addr;
   assign im_wdata = r_im_wdata;
   assign core_rst = r_core_rst;
   assign done     = r_done;
   assign err      = r_err;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Randomized self-checking bench for imem_prog_loader.
// A frame-level reference model builds each image and predicts its writes and final status.
module tb_imem_prog_loader;

   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 1000;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              start;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [15:0]       im_wdata;
   logic              core_rst;
   logic              done;
   logic              err;

   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;
   int          stalls = 0;
   logic [15:0] wv [256];

   imem_prog_loader #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .start    (start),
      .im_we    (im_we),
      .im_addr  (im_addr),
      .im_wdata (im_wdata),
      .core_rst (core_rst),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (im_we === 1'b1) pulses <= pulses + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time exceeded, got=hang exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) chk("ready_timeout", 32'(n), 32'(0));
      stalls += n;
      step();
   endtask

   task automatic gap(input int gmax);
      int k;
      k = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
      if (k > 0) begin
         in_valid = 1'b0;
         repeat (k) step();
      end
   endtask

   // ovr: -1 correct checksum, -2 corrupted checksum, >=0 literal checksum byte
   task automatic send_frame(input int n, input int ovr, input int gmax, input bit poke);
      logic [7:0] cs, cb, sent;
      int base, sbase;
      bit good;
      base  = pulses;
      sbase = stalls;
      cb = 8'(n);
      cs = cb;
      send(cb);
      if (poke) begin
         in_valid = 1'b0;
         start = 1'b1;
         step();
         start = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         gap(gmax);
         send(wv[i][15:8]);
         cs ^= wv[i][15:8];
         gap(gmax);
         send(wv[i][7:0]);
         cs ^= wv[i][7:0];
         chk("wr_we", 32'(im_we), 32'(1));
         chk("wr_addr", 32'(im_addr), 32'(i % 256));
         chk("wr_data", 32'(im_wdata), 32'(wv[i]));
      end
      gap(gmax);
      if (ovr == -1) sent = cs;
      else if (ovr == -2) sent = cs ^ 8'($urandom_range(255, 1));
      else sent = 8'(ovr);
      good = (sent == cs);
      send(sent);
      in_valid = 1'b0;
      chk("fin_done", 32'(done), 32'(good));
      chk("fin_err", 32'(err), 32'(!good));
      chk("fin_core_rst", 32'(core_rst), 32'(!good));
      chk("fin_ready", 32'(in_ready), 32'(0));
      chk("fin_pulses", 32'(pulses - base), 32'(n));
      if (gmax == 0 && !poke) chk("no_stall", 32'(stalls - sbase), 32'(0));
   endtask

   task automatic rearm();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("rearm_done", 32'(done), 32'(0));
      chk("rearm_err", 32'(err), 32'(0));
      chk("rearm_core_rst", 32'(core_rst), 32'(1));
      chk("rearm_ready", 32'(in_ready), 32'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_we"}, 32'(im_we), 32'(0));
      chk({tag, "_addr"}, 32'(im_addr), 32'(0));
      chk({tag, "_wdata"}, 32'(im_wdata), 32'(0));
      chk({tag, "_done"}, 32'(done), 32'(0));
      chk({tag, "_err"}, 32'(err), 32'(0));
      chk({tag, "_core_rst"}, 32'(core_rst), 32'(1));
      chk({tag, "_ready"}, 32'(in_ready), 32'(1));
   endtask

   initial begin
      int base;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      start    = 1'b0;
      step();
      step();
      check_reset_outputs("rst");
      rst = 1'b1;
      step();

      // two-word image with a matching checksum (0x01)
      wv[0] = 16'h00D0;
      wv[1] = 16'h03D0;
      send_frame(2, 8'h01, 0, 1'b0);

      rearm();
      send_frame(2, 8'hFF, 0, 1'b0);

      // timeout: CNT and HI only, then silence
      rearm();
      base = pulses;
      send(8'h01);
      send(8'h12);
      in_valid = 1'b0;
      repeat (TIMEOUT - 1) step();
      chk("to_err_early", 32'(err), 32'(0));
      step();
      chk("to_err", 32'(err), 32'(1));
      chk("to_core_rst", 32'(core_rst), 32'(1));
      chk("to_pulses", 32'(pulses - base), 32'(0));

      // full image, CNT=0, value = address, back-to-back bytes
      rearm();
      for (int i = 0; i < 256; i++) wv[i] = 16'(i);
      send_frame(256, -1, 0, 1'b0);

      // randomized frames; some with gaps, ignored start pulses, or bad checksums
      for (int f = 0; f < 8; f++) begin
         int n;
         rearm();
         n = int'($urandom_range(20, 1));
         for (int i = 0; i < n; i++) wv[i] = 16'($urandom);
         send_frame(n, ($urandom_range(3, 0) == 0) ? -2 : -1, int'($urandom_range(3, 0)),
                    1'($urandom_range(1, 0)));
      end

      // async reset between HI and LO of word 3
      rearm();
      base = pulses;
      send(8'h05);
      for (int i = 0; i < 3; i++) begin
         send(8'($urandom));
         send(8'($urandom));
      end
      send(8'hA5);
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      step();
      rst = 1'b1;
      step();
      chk("mid_pulses", 32'(pulses - base), 32'(3));
      for (int i = 0; i < 3; i++) wv[i] = 16'($urandom);
      send_frame(3, -1, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
